// File: rtl/imem_fetch_resp_pkg.sv
// Shared fetch-pipeline definitions: NOP encoding, address width, responder
// FSM encoding and the line-alignment helper used by the fetch responder.
package imem_fetch_resp_pkg;

   localparam int unsigned ADDR_W    = 64;
   localparam int unsigned TAG_W     = ADDR_W - 3;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   localparam logic [63:0] RESET_PC  = 64'h0000_0000_8000_0000;

   // Responder FSM encoding
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;
   localparam logic [1:0] ST_DROP = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_REQ  = ST_REQ,
      S_WAIT = ST_WAIT,
      S_DROP = ST_DROP
   } fetch_state_e;

   // Doubleword-aligned bus address for a fetch pc
   function automatic logic [ADDR_W-1:0] dw_align(input logic [ADDR_W-1:0] a);
      return {a[ADDR_W-1:3], 3'b000};
   endfunction

endpackage

// File: rtl/imem_fetch_resp_if.sv
// Memory-side read bus between the fetch responder (master) and the
// instruction memory (slave): one address channel, one data channel.
interface imem_fetch_resp_if
   import imem_fetch_resp_pkg::*;
();

   logic              arvalid;
   logic [ADDR_W-1:0] araddr;
   logic              arready;
   logic              rvalid;
   logic [63:0]       rdata;

   modport master (
      output arvalid,
      output araddr,
      input  arready,
      input  rvalid,
      input  rdata
   );

   modport slave (
      input  arvalid,
      input  araddr,
      output arready,
      output rvalid,
      output rdata
   );

endinterface

// File: rtl/imem_fetch_resp.sv
// Instruction fetch responder: a single 64-bit line buffer answers fetches
// in the same cycle; misses are fetched over the read bus while the fetch
// stage is stalled. A redirect during a fetch lets the old read finish and
// throws its data away, so only one read is ever outstanding.
module imem_fetch_resp
   import imem_fetch_resp_pkg::*;
(
   input  logic                 clk,
   input  logic                 rstn,
   input  logic [ADDR_W-1:0]    pc_i,
   input  logic                 flush_i,
   input  logic                 inval_i,
   output logic [31:0]          instr_o,
   output logic                 instr_valid_o,
   output logic                 fetch_stall_o,
   output logic                 misalign_o,
   imem_fetch_resp_if.master    mem
);

   fetch_state_e      state_q;
   logic              arvalid_q;
   logic [ADDR_W-1:0] araddr_q;
   logic              drop_q;      // flush seen while the request was still waiting for arready
   logic              buf_valid_q;
   logic [TAG_W-1:0]  buf_tag_q;
   logic [63:0]       buf_data_q;

   logic              misalign_s;
   logic              hit_s;
   logic              miss_s;

   // Same-cycle hit/miss decode and fetch-stage outputs
   always_comb begin
      misalign_s = (pc_i[1:0] != 2'b00);
      hit_s      = buf_valid_q && (buf_tag_q == pc_i[ADDR_W-1:3]) && !misalign_s;
      miss_s     = !hit_s && !misalign_s;
      if (hit_s) begin
         instr_o = pc_i[2] ? buf_data_q[63:32] : buf_data_q[31:0];
      end else begin
         instr_o = NOP_INSTR;
      end
      instr_valid_o = hit_s;
      fetch_stall_o = miss_s;
      misalign_o    = misalign_s;
   end

   assign mem.arvalid = arvalid_q;
   assign mem.araddr  = araddr_q;

   // Miss FSM, read-bus request registers and line buffer fill/invalidate
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q     <= S_IDLE;
         arvalid_q   <= 1'b0;
         araddr_q    <= '0;
         drop_q      <= 1'b0;
         buf_valid_q <= 1'b0;
         buf_tag_q   <= '0;
         buf_data_q  <= 64'd0;
      end else begin
         // A fill in the same cycle overrides this below
         if (inval_i) begin
            buf_valid_q <= 1'b0;
         end
         case (state_q)
            S_IDLE: begin
               if (miss_s && !flush_i) begin
                  state_q   <= S_REQ;
                  arvalid_q <= 1'b1;
                  araddr_q  <= dw_align(pc_i);
                  drop_q    <= 1'b0;
               end
            end
            S_REQ: begin
               // The request is never retracted; a flush only marks it for dropping
               if (mem.arready) begin
                  arvalid_q <= 1'b0;
                  drop_q    <= 1'b0;
                  state_q   <= (drop_q || flush_i) ? S_DROP : S_WAIT;
               end else if (flush_i) begin
                  drop_q <= 1'b1;
               end
            end
            S_WAIT: begin
               if (mem.rvalid) begin
                  buf_data_q  <= mem.rdata;
                  buf_tag_q   <= araddr_q[ADDR_W-1:3];
                  buf_valid_q <= 1'b1;
                  state_q     <= S_IDLE;
               end else if (flush_i) begin
                  state_q <= S_DROP;
               end
            end
            S_DROP: begin
               if (mem.rvalid) begin
                  state_q <= S_IDLE;
               end
            end
            default: begin
               state_q   <= S_IDLE;
               arvalid_q <= 1'b0;
               drop_q    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imem_fetch_resp.sv
// Bench for imem_fetch_resp: directed scenarios followed by a randomized
// phase checked against a line-buffer reference model; the memory side is
// a configurable-latency responder.
module tb_imem_fetch_resp;
   import imem_fetch_resp_pkg::*;

   logic        clk;
   logic        rstn;
   logic [63:0] pc;
   logic        flush;
   logic        inval;
   logic [31:0] instr;
   logic        instr_valid;
   logic        fetch_stall;
   logic        misalign;

   imem_fetch_resp_if bus ();

   imem_fetch_resp dut (
      .clk           (clk),
      .rstn          (rstn),
      .pc_i          (pc),
      .flush_i       (flush),
      .inval_i       (inval),
      .instr_o       (instr),
      .instr_valid_o (instr_valid),
      .fetch_stall_o (fetch_stall),
      .misalign_o    (misalign),
      .mem           (bus)
   );

   int          n_tests = 0;
   int          n_fail  = 0;
   int          ar_delay_cfg = 0;
   int          r_delay_cfg  = 0;
   bit          pend;
   logic [63:0] pend_addr;
   bit          rand_phase = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory contents: a fixed function of the doubleword address
   function automatic logic [63:0] mem_dw(input logic [63:0] a);
      return {a[31:0] ^ 32'h5A5A_0F0F, ~a[31:0]};
   endfunction

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      logic [63:0] d;
      d = mem_dw({a[63:3], 3'b000});
      return a[2] ? d[63:32] : d[31:0];
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   // Memory responder: arready after ar_delay_cfg cycles, rvalid r_delay_cfg cycles after accept
   initial begin : responder
      int          waited;
      int          r_cnt;
      bit          hs_ar;
      bit          hs_r;
      bit          held;
      bit          held_prev;
      logic [63:0] a_s;
      logic [63:0] a_prev;
      waited = 0; r_cnt = 0; pend = 1'b0; pend_addr = 64'd0;
      held_prev = 1'b0; a_prev = 64'd0;
      bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = 64'd0;
      forever begin
         @(negedge clk);
         hs_ar = bus.arvalid && bus.arready;
         hs_r  = bus.rvalid;
         a_s   = bus.araddr;
         held  = bus.arvalid && !bus.arready && rstn;
         if (held_prev && rstn) begin
            chk("arvalid_held", {63'd0, bus.arvalid}, 64'd1);
            chk("araddr_stable", bus.araddr, a_prev);
         end
         held_prev = held;
         a_prev    = a_s;
         @(posedge clk);
         #1;
         if (hs_r) begin
            bus.rvalid = 1'b0;
            pend = 1'b0;
         end
         if (hs_ar) begin
            chk("one_outstanding", {63'd0, pend}, 64'd0);
            bus.arready = 1'b0;
            waited = 0;
            pend = 1'b1;
            pend_addr = a_s;
            r_cnt = r_delay_cfg;
         end
         if (pend && !bus.rvalid) begin
            if (r_cnt == 0) begin
               bus.rvalid = 1'b1;
               bus.rdata  = mem_dw(pend_addr);
            end else begin
               r_cnt--;
            end
         end
         if (bus.arvalid && !bus.arready) begin
            if (waited >= ar_delay_cfg) bus.arready = 1'b1;
            else waited++;
         end
      end
   end

   // Wait (bounded) for a hit on the current pc, then check the word
   task automatic wait_hit(input string tag, input logic [63:0] a);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         smp();
         if (instr_valid) begin
            seen = 1'b1;
            break;
         end
         step();
      end
      chk({tag, "_hit_seen"}, {63'd0, seen}, 64'd1);
      chk({tag, "_instr"}, {32'd0, instr}, {32'd0, mem_word(a)});
   endtask

   // Wait (bounded) for a read request, then check its address
   task automatic wait_req(input string tag, input logic [63:0] a);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         smp();
         if (bus.arvalid) begin
            seen = 1'b1;
            break;
         end
         step();
      end
      chk({tag, "_req_seen"}, {63'd0, seen}, 64'd1);
      chk({tag, "_araddr"}, bus.araddr, {a[63:3], 3'b000});
   endtask

   // Wait (bounded) for the memory response, checking an expectation each cycle
   task automatic wait_rvalid_quiet(input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         smp();
         chk({tag, "_no_req"}, {63'd0, bus.arvalid}, 64'd0);
         if (bus.rvalid) begin
            seen = 1'b1;
            break;
         end
         step();
      end
      chk({tag, "_rvalid_seen"}, {63'd0, seen}, 64'd1);
   endtask

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stim
      bit          ref_valid;
      logic [60:0] ref_tag;
      bit          exp_mis;
      bit          exp_hit;
      bit          hold;

      rstn = 1'b0; pc = RESET_PC; flush = 1'b0; inval = 1'b0;
      step(); step();
      // Reset state
      smp();
      chk("rst_arvalid", {63'd0, bus.arvalid}, 64'd0);
      chk("rst_araddr", bus.araddr, 64'd0);
      chk("rst_instr_valid", {63'd0, instr_valid}, 64'd0);
      chk("rst_instr", {32'd0, instr}, {32'd0, NOP_INSTR});

      // 1: cold miss, latency 2
      step(); rstn = 1'b1;
      smp();
      chk("t1_c0_stall", {63'd0, fetch_stall}, 64'd1);
      chk("t1_c0_instr", {32'd0, instr}, {32'd0, NOP_INSTR});
      step(); smp();
      chk("t1_c1_arvalid", {63'd0, bus.arvalid}, 64'd1);
      chk("t1_c1_araddr", bus.araddr, 64'h8000_0000);
      step(); smp();
      chk("t1_c2_valid", {63'd0, instr_valid}, 64'd0);
      step(); smp();
      chk("t1_c3_valid", {63'd0, instr_valid}, 64'd1);
      chk("t1_c3_instr", {32'd0, instr}, {32'd0, mem_dw(64'h8000_0000) & 64'hFFFF_FFFF});

      // 2: hit on upper word
      step(); pc = 64'h8000_0004;
      smp();
      chk("t2_valid", {63'd0, instr_valid}, 64'd1);
      chk("t2_instr", {32'd0, instr}, {32'd0, mem_dw(64'h8000_0000) >> 32});
      chk("t2_no_req", {63'd0, bus.arvalid}, 64'd0);
      chk("t2_stall", {63'd0, fetch_stall}, 64'd0);

      // 3: arready held low for 3 cycles
      step(); pc = 64'h8000_0040; ar_delay_cfg = 3;
      smp();
      chk("t3_stall0", {63'd0, fetch_stall}, 64'd1);
      step();
      for (int i = 0; i < 3; i++) begin
         smp();
         chk("t3_arvalid", {63'd0, bus.arvalid}, 64'd1);
         chk("t3_araddr", bus.araddr, 64'h8000_0040);
         chk("t3_stall", {63'd0, fetch_stall}, 64'd1);
         chk("t3_arready_low", {63'd0, bus.arready}, 64'd0);
         step();
      end
      smp();
      chk("t3_arready", {63'd0, bus.arready}, 64'd1);
      ar_delay_cfg = 0;
      step();
      wait_hit("t3", 64'h8000_0040);

      // 4a: flush in WAIT, redirect onto the buffered line
      step(); pc = 64'h8000_0080; r_delay_cfg = 4;
      smp(); step();
      smp();
      chk("t4a_req", {63'd0, bus.arvalid}, 64'd1);
      step(); flush = 1'b1;
      smp();
      chk("t4a_wait_stall", {63'd0, fetch_stall}, 64'd1);
      step(); flush = 1'b0; pc = 64'h8000_0040;
      hold = 1'b0;
      for (int i = 0; i < 12; i++) begin
         smp();
         chk("t4a_drop_hit", {63'd0, instr_valid}, 64'd1);
         chk("t4a_drop_instr", {32'd0, instr}, {32'd0, mem_word(64'h8000_0040)});
         chk("t4a_drop_no_req", {63'd0, bus.arvalid}, 64'd0);
         if (bus.rvalid) begin
            hold = 1'b1;
            break;
         end
         step();
      end
      chk("t4a_rvalid_seen", {63'd0, hold}, 64'd1);
      step(); smp();
      chk("t4a_buf_kept", {32'd0, instr}, {32'd0, mem_word(64'h8000_0040)});
      step(); pc = 64'h8000_0080;
      smp();
      chk("t4a_dropped_miss", {63'd0, instr_valid}, 64'd0);
      step();
      wait_hit("t4a", 64'h8000_0080);

      // 4b: flush in REQ, redirect to a missing line
      step(); pc = 64'h8000_0100; r_delay_cfg = 3;
      smp(); step(); flush = 1'b1;
      smp();
      chk("t4b_req", bus.araddr, 64'h8000_0100);
      step(); flush = 1'b0; pc = 64'h8000_0180;
      smp();
      chk("t4b_drop_stall", {63'd0, fetch_stall}, 64'd1);
      wait_rvalid_quiet("t4b");
      step();
      wait_req("t4b_new", 64'h8000_0180);
      step();
      wait_hit("t4b", 64'h8000_0180);

      // 5: misaligned pc
      step(); pc = 64'h8000_0182;
      smp();
      chk("t5_misalign", {63'd0, misalign}, 64'd1);
      chk("t5_instr", {32'd0, instr}, {32'd0, NOP_INSTR});
      chk("t5_stall", {63'd0, fetch_stall}, 64'd0);
      chk("t5_valid", {63'd0, instr_valid}, 64'd0);
      step(); smp();
      chk("t5_no_req", {63'd0, bus.arvalid}, 64'd0);

      // 6: invalidate, then same pc misses
      step(); pc = 64'h8000_0184; inval = 1'b1;
      smp();
      chk("t6_hit_before", {32'd0, instr}, {32'd0, mem_word(64'h8000_0184)});
      step(); inval = 1'b0;
      smp();
      chk("t6_miss_after", {63'd0, instr_valid}, 64'd0);
      chk("t6_stall_after", {63'd0, fetch_stall}, 64'd1);
      step();
      wait_req("t6", 64'h8000_0180);
      step();
      wait_hit("t6", 64'h8000_0184);

      // 6b: reset while waiting for data, late rvalid ignored
      step(); pc = 64'h8000_0200; r_delay_cfg = 6;
      wait_req("t6b", 64'h8000_0200);
      step(); smp();
      step(); rstn = 1'b0; pc = 64'h8000_0202;
      smp(); step(); smp();
      chk("t6b_rst_arvalid", {63'd0, bus.arvalid}, 64'd0);
      step(); rstn = 1'b1;
      wait_rvalid_quiet("t6b_late");
      step(); pc = 64'h8000_0200;
      smp();
      chk("t6b_buf_invalid", {63'd0, instr_valid}, 64'd0);
      chk("t6b_stall", {63'd0, fetch_stall}, 64'd1);
      step();
      wait_req("t6b_new", 64'h8000_0200);
      step();
      wait_hit("t6b", 64'h8000_0200);

      // Randomized phase against a line-buffer model
      rand_phase = 1'b1;
      ref_valid = 1'b1;
      ref_tag = pc[63:3];
      hold = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         step();
         if (!hold) begin
            pc = 64'h8000_0000 + {58'd0, 4'($urandom_range(0, 15)), 2'b00};
            if ($urandom_range(0, 9) == 0) pc[1:0] = 2'($urandom_range(1, 3));
            ar_delay_cfg = $urandom_range(0, 3);
            r_delay_cfg  = $urandom_range(0, 3);
         end
         inval = ($urandom_range(0, 7) == 0);
         smp();
         exp_mis = (pc[1:0] != 2'b00);
         exp_hit = ref_valid && (ref_tag == pc[63:3]) && !exp_mis;
         chk("rnd_valid", {63'd0, instr_valid}, {63'd0, exp_hit});
         chk("rnd_stall", {63'd0, fetch_stall}, {63'd0, !exp_hit && !exp_mis});
         chk("rnd_misalign", {63'd0, misalign}, {63'd0, exp_mis});
         chk("rnd_instr", {32'd0, instr}, {32'd0, exp_hit ? mem_word(pc) : NOP_INSTR});
         if (bus.arvalid) chk("rnd_araddr", bus.araddr, {pc[63:3], 3'b000});
         if (bus.rvalid) begin
            ref_valid = 1'b1;
            ref_tag   = pend_addr[63:3];
         end else if (inval) begin
            ref_valid = 1'b0;
         end
         hold = !exp_hit && !exp_mis;
      end
      inval = 1'b0;

      step();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
